// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-fed, configurable width/parity/stop bits,
// internal bit-period timer, back-to-back frame draining.
module uart_tx_framed #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 9,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 busy,
  output logic                 overflow
);

  localparam int DIV = CLK_HZ / BAUD_RATE;
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TIMER_MAX = TW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push, pop, wrap;

  assign ready    = (count_q < DEPTH_C);
  assign busy     = (state_q != S_IDLE) || (count_q != '0);
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign push     = send && ready;
  assign wrap     = (timer_q == TIMER_MAX);

  always_comb begin
    state_d   = state_q;
    timer_d   = wrap ? '0 : timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (wrap) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (wrap) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        // Last stop period ending with work queued chains straight into START.
        if (wrap) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = mem[rd_ptr_q];
      par_d   = (^mem[rd_ptr_q]) ^ ODD_PAR;
      timer_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= send && !ready;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= data;
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four parameterisations sharing clock/reset,
// hand-written frame bit patterns checked cycle by cycle on the tx line.
module tb_uart_tx_framed;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       send_a = 0, send_b = 0, send_c = 0, send_d = 0;
  logic [7:0] data_a = 0, data_b = 0, data_c = 0;
  logic [8:0] data_d = 0;
  logic tx_a, tx_b, tx_c, tx_d;
  logic ready_a, ready_b, ready_c, ready_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic ovf_a, ovf_b, ovf_c, ovf_d;

  // a: DIV=16, 8 bits, even parity, 1 stop
  uart_tx_framed #(.CLK_HZ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clock(clock), .reset(reset), .send(send_a), .data(data_a),
    .tx(tx_a), .ready(ready_a), .busy(busy_a), .overflow(ovf_a));
  // b: DIV=4, 8 bits, odd parity, 1 stop
  uart_tx_framed #(.CLK_HZ(8), .BAUD_RATE(2), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clock(clock), .reset(reset), .send(send_b), .data(data_b),
    .tx(tx_b), .ready(ready_b), .busy(busy_b), .overflow(ovf_b));
  // c: DIV=4, 8 bits, no parity, 2 stop
  uart_tx_framed #(.CLK_HZ(8), .BAUD_RATE(2), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clock(clock), .reset(reset), .send(send_c), .data(data_c),
    .tx(tx_c), .ready(ready_c), .busy(busy_c), .overflow(ovf_c));
  // d: DIV=4, 9 bits, no parity, 1 stop
  uart_tx_framed #(.CLK_HZ(8), .BAUD_RATE(2), .DATA_BITS(9), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
    .clock(clock), .reset(reset), .send(send_d), .data(data_d),
    .tx(tx_d), .ready(ready_d), .busy(busy_d), .overflow(ovf_d));

  int   sel = 0;
  logic tx_mon, busy_mon;
  always_comb begin
    tx_mon   = tx_a;
    busy_mon = busy_a;
    case (sel)
      1: begin tx_mon = tx_b; busy_mon = busy_b; end
      2: begin tx_mon = tx_c; busy_mon = busy_c; end
      3: begin tx_mon = tx_d; busy_mon = busy_d; end
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int which, input logic [8:0] val);
    case (which)
      0: begin send_a = 1'b1; data_a = val[7:0]; end
      1: begin send_b = 1'b1; data_b = val[7:0]; end
      2: begin send_c = 1'b1; data_c = val[7:0]; end
      default: begin send_d = 1'b1; data_d = val; end
    endcase
    step();
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0; send_d = 1'b0;
  endtask

  // frame[k] is the k-th line bit in time order (start bit at index 0).
  task automatic expect_frame(input string tag, input int div,
                              input logic [15:0] frame, input int nbits);
    for (int k = 0; k < nbits * div; k++) begin
      step();
      check(tag, tx_mon, frame[k / div]);
      if (k < nbits * div - 1) check({tag, "_busy"}, busy_mon, 1);
    end
  endtask

  initial begin
    // reset values
    step(); step();
    check("rst_tx", tx_a, 1);
    check("rst_ready", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_tx_d", tx_d, 1);
    check("rst_busy_c", busy_c, 0);
    reset = 1'b0;
    step();

    // even parity 0xA5, DIV=16
    sel = 0;
    push(0, 9'h0A5);
    check("a5_busy_push", busy_a, 1);
    step();
    check("a5_lat", tx_a, 1);
    expect_frame("a5", 16, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    check("a5_busy_end", busy_a, 0);

    // odd parity 0x01 -> parity bit 0
    sel = 1;
    push(1, 9'h001);
    step();
    check("odd_lat", tx_b, 1);
    expect_frame("odd01", 4, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
    check("odd_busy_end", busy_b, 0);

    // no parity, two stop bits
    sel = 2;
    push(2, 9'h007);
    step();
    check("stop2_lat", tx_c, 1);
    expect_frame("stop2", 4, {5'b0, 2'b11, 8'h07, 1'b0}, 11);
    check("stop2_busy_end", busy_c, 0);

    // 9-bit payload
    sel = 3;
    push(3, 9'h1FF);
    step();
    check("d9_lat", tx_d, 1);
    expect_frame("d9", 4, {5'b0, 1'b1, 9'h1FF, 1'b0}, 11);
    check("d9_busy_end", busy_d, 0);

    // FIFO fill while a frame runs; push edge of 0x11 is N
    sel = 0;
    push(0, 9'h011);
    step(); step(); step();
    push(0, 9'h05B);
    push(0, 9'h0C3);
    push(0, 9'h007);
    check("fill_ready3", ready_a, 1);
    push(0, 9'h0F0);
    check("fill_ready4", ready_a, 0);
    check("fill_ovf_before", ovf_a, 0);
    push(0, 9'h099);
    check("fill_ovf", ovf_a, 1);
    check("fill_ready_full", ready_a, 0);
    step();
    check("fill_ovf_clear", ovf_a, 0);
    repeat (168) step();
    check("fill_first_stop", tx_a, 1);
    expect_frame("fill0", 16, {5'b0, 1'b1, 1'b1, 8'h5B, 1'b0}, 11);
    expect_frame("fill1", 16, {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11);
    expect_frame("fill2", 16, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    expect_frame("fill3", 16, {5'b0, 1'b1, 1'b0, 8'hF0, 1'b0}, 11);
    check("fill_busy_end", busy_a, 0);
    step(); step();

    // push landing on the pop at the end of a stop bit with count=1
    push(0, 9'h081);
    step();
    check("sim_lat", tx_a, 1);
    step();
    check("sim_start", tx_a, 0);
    step(); step();
    push(0, 9'h03D);
    repeat (171) step();
    push(0, 9'h042);
    check("sim_stop", tx_a, 1);
    check("sim_ready", ready_a, 1);
    expect_frame("sim1", 16, {5'b0, 1'b1, 1'b1, 8'h3D, 1'b0}, 11);
    expect_frame("sim2", 16, {5'b0, 1'b1, 1'b0, 8'h42, 1'b0}, 11);
    check("sim_busy_end", busy_a, 0);
    step(); step();

    // reset during the 4th data bit with two words queued
    push(0, 9'h012);
    push(0, 9'h034);
    push(0, 9'h056);
    repeat (67) step();
    check("rst_mid_d3", tx_a, 0);
    check("rst_mid_busy", busy_a, 1);
    reset = 1'b1;
    step();
    check("rst_mid_tx", tx_a, 1);
    check("rst_mid_busy0", busy_a, 0);
    check("rst_mid_ready", ready_a, 1);
    reset = 1'b0;
    step(); step();
    check("rst_mid_drop", busy_a, 0);
    check("rst_mid_idle", tx_a, 1);
    push(0, 9'h03C);
    step();
    check("post_lat", tx_a, 1);
    expect_frame("post3c", 16, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    check("post_busy_end", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
